// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational; updates, clear and the mispredict statistic are registered.
module bpu_btb #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            clear,
  output logic [31:0]     stat_mispred
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAGW-1:0]     r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [31:0]         r_stat;

  logic [IDXW-1:0] w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic [IDXW-1:0] w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;
  logic            w_unused;

  assign w_lk_idx  = lk_pc[IDXW+1:2];
  assign w_lk_tag  = lk_pc[XLEN-1:IDXW+2];
  assign w_upd_idx = upd_pc[IDXW+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDXW+2];
  // Byte-offset bits never take part in indexing or tag compare.
  assign w_unused  = ^{lk_pc[1:0], upd_pc[1:0]};

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_comb begin
    pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_BITS-1];
    pred_target = pred_taken ? r_target[w_lk_idx] : lk_pc + XLEN'(4);
  end

  assign stat_mispred = r_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_stat  <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tag[IDXW'(i)]    <= '0;
        r_target[IDXW'(i)] <= '0;
        r_ctr[IDXW'(i)]    <= CTR_WNT;
      end
    end else begin
      if (upd_valid && upd_mispredict && (r_stat != '1))
        r_stat <= r_stat + 32'd1;

      // Clear wins over a same-cycle update; only the valid bits are dropped.
      if (clear) begin
        r_valid <= '0;
      end else if (upd_valid) begin
        if (w_upd_hit) begin
          if (upd_taken) begin
            r_target[w_upd_idx] <= upd_target;
            if (r_ctr[w_upd_idx] != CTR_MAX)
              r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + CTR_BITS'(1);
          end else if (r_ctr[w_upd_idx] != '0) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - CTR_BITS'(1);
          end
        end else if (upd_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= upd_target;
          r_ctr[w_upd_idx]    <= CTR_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboarded bench for bpu_btb: directed scenarios followed by random traffic,
// checked against a table-of-entries reference model.
module tb_bpu_btb;

  localparam int XLEN     = 32;
  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int IDXW     = $clog2(ENTRIES);
  localparam int CMAX     = (1 << CTR_BITS) - 1;
  localparam int CWT      = 1 << (CTR_BITS - 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;
  logic            clear;
  logic [31:0]     stat_mispred;

  bpu_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lk_pc         (lk_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .clear         (clear),
    .stat_mispred  (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] stat;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per direct-mapped slot.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  longint      m_stat;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = CWT - 1;
      m_tgt[i]   = '0;
    end
    m_stat = 0;
  endfunction

  function automatic exp_t predict(logic [31:0] pc, string nm);
    exp_t e;
    int unsigned i;
    i      = idx_of(pc);
    e.hit  = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken = e.hit && (m_ctr[i] >= CWT);
    e.tgt  = e.taken ? m_tgt[i] : pc + 32'd4;
    e.stat = 32'(m_stat);
    e.nm   = nm;
    return e;
  endfunction

  function automatic void model_update(logic uv, logic [31:0] pc, logic tk,
                                       logic [31:0] tgt, logic mis, logic clr);
    int unsigned i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (uv && mis && m_stat < 64'hFFFF_FFFF) m_stat++;
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (uv) begin
      if (hit) begin
        m_ctr[i] = tk ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (tk) m_tgt[i] = tgt;
      end else if (tk) begin
        m_valid[i] = 1;
        m_tag[i]   = tag_of(pc);
        m_tgt[i]   = tgt;
        m_ctr[i]   = CWT;
      end
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: lookup outputs are always presented; compare at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".hit"},    32'(pred_hit),   32'(e.hit));
        chk({e.nm, ".taken"},  32'(pred_taken), 32'(e.taken));
        chk({e.nm, ".target"}, pred_target,     e.tgt);
        chk({e.nm, ".stat"},   stat_mispred,    e.stat);
      end
    end
  end

  task automatic step(logic [31:0] lk, logic uv, logic [31:0] upc, logic tk,
                      logic [31:0] tgt, logic mis, logic clr, string nm);
    @(posedge clk);
    #1;
    lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_taken = tk;
    upd_target = tgt; upd_mispredict = mis; clear = clr;
    q.push_back(predict(lk, nm));
    model_update(uv, upc, tk, tgt, mis, clr);
  endtask

  task automatic look(logic [31:0] lk, string nm);
    step(lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, nm);
  endtask

  // Reset asserted after an edge with an update pending, checked before the next edge.
  task automatic mid_reset(logic [31:0] lk, string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    lk_pc = lk; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'hDEAD_BEE0; upd_mispredict = 1'b1; clear = 1'b0;
    model_reset();
    q.push_back(predict(lk, nm));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  function automatic logic [31:0] rpc();
    return {26'($urandom_range(0, 3)), 4'($urandom_range(0, ENTRIES - 1)),
            2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [31:0] pc;
    logic uv, tk, clr, mis;
    rst_n = 1'b0;
    lk_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    q.push_back(predict(32'h100, "in_reset"));
    @(negedge clk);
    #1 rst_n = 1'b1;

    look(32'h100, "post_reset");
    step(32'h0, 1, 32'h100, 1, 32'h80, 0, 0, "alloc");
    look(32'h100, "alloc_hit");
    step(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, "nt1");
    step(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, "nt2");
    step(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, "nt3_sat0");
    for (int i = 0; i < 4; i++)
      step(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, "t_up");
    look(32'h100, "sat3");
    step(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, "from3");
    look(32'h100, "ctr2");

    look(32'h140, "alias_miss");
    step(32'h0, 1, 32'h140, 1, 32'h200, 0, 0, "alias_alloc");
    look(32'h100, "evicted");
    look(32'h140, "alias_hit");

    step(32'h140, 1, 32'h100, 1, 32'h80, 0, 1, "clear_upd");
    look(32'h100, "after_clear");
    look(32'h140, "after_clear2");
    step(32'h0, 1, 32'h100, 1, 32'h80, 0, 0, "realloc");
    step(32'h100, 1, 32'h100, 1, 32'h300, 0, 0, "same_cycle");
    look(32'h100, "new_target");
    look(32'hFFFF_FFFC, "wrap");

    for (int i = 0; i < 3; i++)
      step(32'h100, 1, 32'h100, 1, 32'h300, 1, 0, "mis");
    step(32'h100, 0, 32'h0, 0, 32'h0, 1, 0, "mis_no_valid");
    look(32'h100, "stat3");
    mid_reset(32'h100, "async_rst");
    look(32'h100, "rst_miss");
    look(32'h140, "rst_miss2");

    for (int i = 0; i < 500; i++) begin
      pc  = rpc();
      uv  = ($urandom_range(0, 9) < 6);
      tk  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 49) == 0);
      mis = !clr && ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 1) == 1) ? pc : rpc(), uv, pc, tk, $urandom(), mis, clr, "rand");
    end

    @(posedge clk);
    #1 upd_valid = 1'b0; clear = 1'b0; upd_mispredict = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu_btb.md
BPU_BTB -- requirements
Module: bpu_btb

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/target width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries; power of two, >= 2.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating-counter width; range 1..4.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port lk_pc  input  XLEN  fetch-stage PC to look up.
REQ-007 SHALL have port pred_hit  output  1  valid entry with matching tag exists for lk_pc.
REQ-008 SHALL have port pred_taken  output  1  predict taken.
REQ-009 SHALL have port pred_target  output  XLEN  predicted next PC.
REQ-010 SHALL have port upd_valid  input  1  resolved branch update this cycle.
REQ-011 SHALL have port upd_pc  input  XLEN  PC of resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-013 SHALL have port upd_target  input  XLEN  actual taken target.
REQ-014 SHALL have port upd_mispredict  input  1  pipeline flushed for this branch.
REQ-015 SHALL have port clear  input  1  synchronous invalidate-all, e.g. on interrupt/context change.
REQ-016 SHALL have port stat_mispred  output  32  saturating mispredict count.

Function
REQ-017 SHALL use IDXW = log2(ENTRIES), index = pc[IDXW+1:2], tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
REQ-018 SHALL make lookup purely combinational, zero latency: pred_hit = valid[idx] AND tag match.
REQ-019 SHALL drive pred_taken = pred_hit AND counter MSB.
REQ-020 SHALL drive pred_target = stored target when pred_taken, else lk_pc+4 (modulo 2^XLEN).
REQ-021 On upd_valid with hit, SHALL increment the counter when taken, decrement when not taken, saturating at 2^CTR_BITS-1 and 0.
REQ-022 On upd_valid with hit and upd_taken, SHALL overwrite the stored target with upd_target.
REQ-023 On upd_valid with miss and upd_taken, SHALL allocate: valid=1, tag, target=upd_target, counter = 2^(CTR_BITS-1) (weakly taken), replacing any aliased entry.
REQ-024 On upd_valid with miss and not taken, SHALL leave all state unchanged.
REQ-025 Same-cycle lookup and update to the same index SHALL return pre-update contents; no bypass.
REQ-026 clear SHALL zero all valid bits at the next edge, taking priority over a simultaneous upd_valid; counters, targets and stat_mispred are unaffected.
REQ-027 stat_mispred SHALL increment when upd_valid AND upd_mispredict, and hold at 0xFFFFFFFF; upd_mispredict without upd_valid is ignored.
REQ-028 Entries other than the indexed one SHALL never change on an update.

Reset
REQ-029 rst_n low SHALL immediately clear all valid bits, set all counters to 2^(CTR_BITS-1)-1 (weakly not-taken), zero targets and zero stat_mispred, regardless of clock.
REQ-030 During and after reset, outputs SHALL be pred_hit=0, pred_taken=0, pred_target=lk_pc+4, stat_mispred=0.
REQ-031 Reset asserted mid-update SHALL win; no partial entry write survives.

Verification (ENTRIES=16, CTR_BITS=2, XLEN=32)
REQ-032 After reset, lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-033 Update pc=0x100, taken, target=0x80; next cycle lookup 0x100 -> hit=1, taken=1, target=0x80 (counter=2).
REQ-034 From REQ-033, two not-taken updates -> counter 0, taken=0, target=0x104; third not-taken -> stays 0; four taken -> counter saturates at 3.
REQ-035 With 0x100 allocated, lookup 0x140 (same index 0, different tag) -> hit=0; taken update at 0x140 target 0x200 -> lookup 0x100 misses, lookup 0x140 hits with target 0x200.
REQ-036 Same-cycle clear and taken update to 0x100 -> next cycle 0x100 misses; update and lookup of 0x100 in the same cycle -> old prediction shown.
REQ-037 Three updates with upd_mispredict=1, then rst_n pulsed low between edges -> stat_mispred reads 3, then 0 asynchronously, and all lookups miss.
